// File: rtl/ex_muldiv_sequencer_if.sv
// ex_muldiv_sequencer_if
//   Issue/result bundle between the ID/EX control path and the iterative
//   multiply/divide unit.
//   Ports (master = issuing side, slave = muldiv unit):
//     i_start, i_op, i_rs, i_rt, i_abort : issue request and pipeline flush
//     o_busy, o_done, o_hi, o_lo         : status and architectural HI/LO
interface ex_muldiv_sequencer_if #(
  parameter int NB_BITS = 32
);
  logic               i_start;
  logic [2:0]         i_op;
  logic [NB_BITS-1:0] i_rs;
  logic [NB_BITS-1:0] i_rt;
  logic               i_abort;
  logic               o_busy;
  logic               o_done;
  logic [NB_BITS-1:0] o_hi;
  logic [NB_BITS-1:0] o_lo;

  modport master (
    output i_start, i_op, i_rs, i_rt, i_abort,
    input  o_busy, o_done, o_hi, o_lo
  );

  modport slave (
    input  i_start, i_op, i_rs, i_rt, i_abort,
    output o_busy, o_done, o_hi, o_lo
  );
endinterface

// File: rtl/ex_muldiv_sequencer.sv
// ex_muldiv_sequencer
//   Iterative MULT/MULTU/DIV/DIVU engine plus MTHI/MTLO; owns HI/LO.
//   Multiply is shift-add and divide is restoring, both on operand
//   magnitudes, one iteration per clock, followed by a single sign-fix
//   cycle that writes HI/LO.
//   Ports:
//     i_clk  : clock, rising edge
//     i_rst  : synchronous active-high reset
//     bus    : ex_muldiv_sequencer_if.slave (issue inputs, busy/done, HI/LO)
module ex_muldiv_sequencer #(
  parameter int NB_BITS = 32,
  parameter int NB_CNT  = 6
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  ex_muldiv_sequencer_if.slave  bus
);

  localparam logic [2:0] OP_MULT  = 3'd1;
  localparam logic [2:0] OP_MULTU = 3'd2;
  localparam logic [2:0] OP_DIV   = 3'd3;
  localparam logic [2:0] OP_DIVU  = 3'd4;
  localparam logic [2:0] OP_MTHI  = 3'd5;
  localparam logic [2:0] OP_MTLO  = 3'd6;
  localparam logic [NB_CNT-1:0] LAST_ITER = NB_CNT'(NB_BITS - 1);

  typedef enum logic [1:0] {IDLE, MUL, DIV, FIX} state_t;

  state_t                 state_q, state_d;
  logic [NB_CNT-1:0]      cnt_q, cnt_d;
  // MUL: {partial product, remaining multiplier}; DIV: {remainder, dividend/quotient}
  logic [2*NB_BITS-1:0]   acc_q, acc_d;
  // MUL: multiplicand magnitude; DIV: raw rs, kept for the divide-by-zero HI value
  logic [NB_BITS-1:0]     a_q, a_d;
  logic [NB_BITS-1:0]     b_q, b_d;   // divisor magnitude
  logic                   is_div_q, is_div_d;
  logic                   neg_res_q, neg_res_d;
  logic                   neg_rem_q, neg_rem_d;
  logic                   div0_q, div0_d;
  logic [NB_BITS-1:0]     hi_q, hi_d;
  logic [NB_BITS-1:0]     lo_q, lo_d;
  logic                   busy_q, busy_d;
  logic                   done_q, done_d;

  logic                   is_signed;
  logic [NB_BITS-1:0]     rs_mag, rt_mag;
  logic [NB_BITS:0]       mul_sum;
  logic [NB_BITS:0]       div_shift, div_diff;
  logic [2*NB_BITS-1:0]   prod_fix;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      acc_q     <= '0;
      a_q       <= '0;
      b_q       <= '0;
      is_div_q  <= 1'b0;
      neg_res_q <= 1'b0;
      neg_rem_q <= 1'b0;
      div0_q    <= 1'b0;
      hi_q      <= '0;
      lo_q      <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      acc_q     <= acc_d;
      a_q       <= a_d;
      b_q       <= b_d;
      is_div_q  <= is_div_d;
      neg_res_q <= neg_res_d;
      neg_rem_q <= neg_rem_d;
      div0_q    <= div0_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    acc_d     = acc_q;
    a_d       = a_q;
    b_d       = b_q;
    is_div_d  = is_div_q;
    neg_res_d = neg_res_q;
    neg_rem_d = neg_rem_q;
    div0_d    = div0_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    done_d    = 1'b0;

    is_signed = (bus.i_op == OP_MULT) || (bus.i_op == OP_DIV);
    rs_mag    = (is_signed && bus.i_rs[NB_BITS-1]) ? -bus.i_rs : bus.i_rs;
    rt_mag    = (is_signed && bus.i_rt[NB_BITS-1]) ? -bus.i_rt : bus.i_rt;

    mul_sum   = {1'b0, acc_q[2*NB_BITS-1:NB_BITS]} + (acc_q[0] ? {1'b0, a_q} : '0);
    div_shift = {acc_q[2*NB_BITS-1:NB_BITS], acc_q[NB_BITS-1]};
    div_diff  = div_shift - {1'b0, b_q};
    prod_fix  = neg_res_q ? -acc_q : acc_q;

    unique case (state_q)
      IDLE: begin
        if (bus.i_start && !bus.i_abort) begin
          unique case (bus.i_op)
            OP_MULT, OP_MULTU, OP_DIV, OP_DIVU: begin
              is_div_d  = (bus.i_op == OP_DIV) || (bus.i_op == OP_DIVU);
              neg_res_d = is_signed && (bus.i_rs[NB_BITS-1] ^ bus.i_rt[NB_BITS-1]);
              neg_rem_d = is_signed && bus.i_rs[NB_BITS-1];
              div0_d    = (bus.i_rt == '0);
              cnt_d     = '0;
              if (is_div_d) begin
                acc_d   = {{NB_BITS{1'b0}}, rs_mag};
                a_d     = bus.i_rs;
                b_d     = rt_mag;
                state_d = DIV;
              end else begin
                acc_d   = {{NB_BITS{1'b0}}, rt_mag};
                a_d     = rs_mag;
                state_d = MUL;
              end
            end
            OP_MTHI: hi_d = bus.i_rs;
            OP_MTLO: lo_d = bus.i_rs;
            default: ;
          endcase
        end
      end
      MUL: begin
        acc_d = {mul_sum, acc_q[NB_BITS-1:1]};
        cnt_d = cnt_q + NB_CNT'(1);
        if (cnt_q == LAST_ITER) state_d = FIX;
      end
      DIV: begin
        // Remainder stays below the divisor, so the top bit of the trial
        // difference is the borrow and the N-bit slice is the new remainder.
        if (!div_diff[NB_BITS]) acc_d = {div_diff[NB_BITS-1:0], acc_q[NB_BITS-2:0], 1'b1};
        else                    acc_d = {div_shift[NB_BITS-1:0], acc_q[NB_BITS-2:0], 1'b0};
        cnt_d = cnt_q + NB_CNT'(1);
        if (cnt_q == LAST_ITER) state_d = FIX;
      end
      FIX: begin
        if (!is_div_q) begin
          hi_d = prod_fix[2*NB_BITS-1:NB_BITS];
          lo_d = prod_fix[NB_BITS-1:0];
        end else if (div0_q) begin
          lo_d = '1;
          hi_d = a_q;
        end else begin
          lo_d = neg_res_q ? -acc_q[NB_BITS-1:0] : acc_q[NB_BITS-1:0];
          hi_d = neg_rem_q ? -acc_q[2*NB_BITS-1:NB_BITS] : acc_q[2*NB_BITS-1:NB_BITS];
        end
        done_d  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // A flush kills any in-flight op, including one about to write HI/LO.
    if (bus.i_abort && (state_q != IDLE)) begin
      state_d = IDLE;
      hi_d    = hi_q;
      lo_d    = lo_q;
      done_d  = 1'b0;
    end

    busy_d = (state_d != IDLE);
  end

  assign bus.o_busy = busy_q;
  assign bus.o_done = done_q;
  assign bus.o_hi   = hi_q;
  assign bus.o_lo   = lo_q;

endmodule

// File: tb/tb_ex_muldiv_sequencer.sv
// tb_ex_muldiv_sequencer
//   Directed bench for ex_muldiv_sequencer: reset, multiply/divide results,
//   latency, MTHI/MTLO, ignored issues while busy, abort and mid-op reset.
module tb_ex_muldiv_sequencer;

  localparam int NB = 32;

  logic clk;
  logic rst;
  int   checks;
  int   failures;

  ex_muldiv_sequencer_if #(.NB_BITS(NB)) bus ();

  ex_muldiv_sequencer #(.NB_BITS(NB), .NB_CNT(6)) dut (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one op across a single edge (E0); returns 1 time unit after E0.
  task automatic issue(input logic [2:0] op, input logic [NB-1:0] rs, input logic [NB-1:0] rt);
    bus.i_start = 1'b1;
    bus.i_op    = op;
    bus.i_rs    = rs;
    bus.i_rt    = rt;
    tick();
    bus.i_start = 1'b0;
    bus.i_op    = 3'd0;
  endtask

  // Count cycles with o_busy=1 until o_done shows, bounded.
  task automatic wait_done(output int busy_cycles, output bit done_seen);
    busy_cycles = 0;
    done_seen   = 1'b0;
    for (int i = 0; i < 100; i++) begin
      if (bus.o_done) begin
        done_seen = 1'b1;
        break;
      end
      if (bus.o_busy) busy_cycles++;
      tick();
    end
  endtask

  task automatic test_reset();
    checks++;
    if ({bus.o_busy, bus.o_done} !== 2'b00) begin
      failures++;
      $display("FAIL reset_flags busy/done=%b required 00", {bus.o_busy, bus.o_done});
    end
    checks++;
    if ({bus.o_hi, bus.o_lo} !== 64'd0) begin
      failures++;
      $display("FAIL reset_hilo hi=%h lo=%h required 0/0", bus.o_hi, bus.o_lo);
    end
    $display("reset: busy=%b done=%b hi=%h lo=%h", bus.o_busy, bus.o_done, bus.o_hi, bus.o_lo);
  endtask

  task automatic test_multu();
    int busy_cycles;
    bit done_seen;
    issue(3'd2, 32'hFFFFFFFF, 32'hFFFFFFFF);
    wait_done(busy_cycles, done_seen);
    checks++;
    if (done_seen !== 1'b1) begin
      failures++;
      $display("FAIL multu_done done_seen=%b required 1", done_seen);
    end
    checks++;
    if (busy_cycles !== 33) begin
      failures++;
      $display("FAIL multu_latency busy_cycles=%0d required 33", busy_cycles);
    end
    checks++;
    if (bus.o_busy !== 1'b0) begin
      failures++;
      $display("FAIL multu_busy_drop busy=%b required 0", bus.o_busy);
    end
    checks++;
    if ({bus.o_hi, bus.o_lo} !== 64'hFFFFFFFE_00000001) begin
      failures++;
      $display("FAIL multu_result hi=%h lo=%h required fffffffe/00000001", bus.o_hi, bus.o_lo);
    end
    $display("MULTU ffffffff*ffffffff: busy=%0d hi=%h lo=%h", busy_cycles, bus.o_hi, bus.o_lo);
    tick();
    checks++;
    if (bus.o_done !== 1'b0) begin
      failures++;
      $display("FAIL multu_done_pulse done=%b required 0", bus.o_done);
    end
  endtask

  task automatic test_signed();
    int busy_cycles;
    bit done_seen;
    issue(3'd1, -32'sd3, 32'd7);
    wait_done(busy_cycles, done_seen);
    checks++;
    if ({done_seen, bus.o_hi, bus.o_lo} !== {1'b1, 64'hFFFFFFFF_FFFFFFEB}) begin
      failures++;
      $display("FAIL mult_neg done=%b hi=%h lo=%h required 1 ffffffff/ffffffeb", done_seen, bus.o_hi, bus.o_lo);
    end
    $display("MULT -3*7: hi=%h lo=%h", bus.o_hi, bus.o_lo);
    // Back to back: issue in the same cycle o_done is high.
    issue(3'd3, -32'sd7, 32'd2);
    wait_done(busy_cycles, done_seen);
    checks++;
    if ({done_seen, bus.o_hi, bus.o_lo} !== {1'b1, 64'hFFFFFFFF_FFFFFFFD}) begin
      failures++;
      $display("FAIL div_neg done=%b hi=%h lo=%h required 1 ffffffff/fffffffd", done_seen, bus.o_hi, bus.o_lo);
    end
    $display("DIV -7/2: hi=%h lo=%h", bus.o_hi, bus.o_lo);
    issue(3'd4, 32'd100, 32'd7);
    wait_done(busy_cycles, done_seen);
    checks++;
    if ({done_seen, busy_cycles, bus.o_hi, bus.o_lo} !== {1'b1, 32'd33, 32'd2, 32'd14}) begin
      failures++;
      $display("FAIL divu_100_7 done=%b busy=%0d hi=%h lo=%h required 1 33 2/14", done_seen, busy_cycles, bus.o_hi, bus.o_lo);
    end
    $display("DIVU 100/7: hi=%h lo=%h", bus.o_hi, bus.o_lo);
  endtask

  task automatic test_div_edges();
    int busy_cycles;
    bit done_seen;
    issue(3'd4, 32'd5, 32'd0);
    wait_done(busy_cycles, done_seen);
    checks++;
    if ({done_seen, busy_cycles, bus.o_hi, bus.o_lo} !== {1'b1, 32'd33, 32'h00000005, 32'hFFFFFFFF}) begin
      failures++;
      $display("FAIL divu_by_zero done=%b busy=%0d hi=%h lo=%h required 1 33 00000005/ffffffff", done_seen, busy_cycles, bus.o_hi, bus.o_lo);
    end
    $display("DIVU 5/0: hi=%h lo=%h", bus.o_hi, bus.o_lo);
    issue(3'd3, -32'sd9, 32'd0);
    wait_done(busy_cycles, done_seen);
    checks++;
    if ({done_seen, bus.o_hi, bus.o_lo} !== {1'b1, 32'hFFFFFFF7, 32'hFFFFFFFF}) begin
      failures++;
      $display("FAIL div_by_zero_signed done=%b hi=%h lo=%h required 1 fffffff7/ffffffff", done_seen, bus.o_hi, bus.o_lo);
    end
    $display("DIV -9/0: hi=%h lo=%h", bus.o_hi, bus.o_lo);
    issue(3'd3, 32'h80000000, 32'hFFFFFFFF);
    wait_done(busy_cycles, done_seen);
    checks++;
    if ({done_seen, bus.o_hi, bus.o_lo} !== {1'b1, 32'h00000000, 32'h80000000}) begin
      failures++;
      $display("FAIL div_overflow done=%b hi=%h lo=%h required 1 00000000/80000000", done_seen, bus.o_hi, bus.o_lo);
    end
    $display("DIV 80000000/-1: hi=%h lo=%h", bus.o_hi, bus.o_lo);
  endtask

  task automatic test_mthi_mtlo();
    issue(3'd5, 32'h12345678, 32'd0);
    checks++;
    if ({bus.o_busy, bus.o_done, bus.o_hi, bus.o_lo} !== {2'b00, 32'h12345678, 32'h80000000}) begin
      failures++;
      $display("FAIL mthi busy=%b done=%b hi=%h lo=%h required 0 0 12345678/80000000", bus.o_busy, bus.o_done, bus.o_hi, bus.o_lo);
    end
    $display("MTHI 12345678: hi=%h lo=%h", bus.o_hi, bus.o_lo);
    issue(3'd6, 32'h9ABCDEF0, 32'd0);
    checks++;
    if ({bus.o_busy, bus.o_done, bus.o_hi, bus.o_lo} !== {2'b00, 32'h12345678, 32'h9ABCDEF0}) begin
      failures++;
      $display("FAIL mtlo busy=%b done=%b hi=%h lo=%h required 0 0 12345678/9abcdef0", bus.o_busy, bus.o_done, bus.o_hi, bus.o_lo);
    end
    $display("MTLO 9abcdef0: hi=%h lo=%h", bus.o_hi, bus.o_lo);
    issue(3'd7, 32'h55555555, 32'd1);
    checks++;
    if ({bus.o_busy, bus.o_hi, bus.o_lo} !== {1'b0, 32'h12345678, 32'h9ABCDEF0}) begin
      failures++;
      $display("FAIL reserved_op busy=%b hi=%h lo=%h required 0 12345678/9abcdef0", bus.o_busy, bus.o_hi, bus.o_lo);
    end
  endtask

  task automatic test_busy_ignore();
    int busy_cycles;
    bit done_seen;
    issue(3'd1, 32'd6, 32'd7);
    repeat (3) tick();
    issue(3'd5, 32'h0000DEAD, 32'd0);
    checks++;
    if ({bus.o_busy, bus.o_hi} !== {1'b1, 32'h12345678}) begin
      failures++;
      $display("FAIL busy_mthi_ignored busy=%b hi=%h required 1 12345678", bus.o_busy, bus.o_hi);
    end
    issue(3'd1, 32'd100, 32'd100);
    wait_done(busy_cycles, done_seen);
    checks++;
    if ({done_seen, busy_cycles, bus.o_hi, bus.o_lo} !== {1'b1, 32'd28, 32'd0, 32'd42}) begin
      failures++;
      $display("FAIL busy_ignore_result done=%b busy=%0d hi=%h lo=%h required 1 28 0/42", done_seen, busy_cycles, bus.o_hi, bus.o_lo);
    end
    $display("MULT 6*7 with ignored issues: hi=%h lo=%h", bus.o_hi, bus.o_lo);
    tick();
    checks++;
    if ({bus.o_busy, bus.o_done} !== 2'b00) begin
      failures++;
      $display("FAIL busy_ignore_no_second busy=%b done=%b required 0 0", bus.o_busy, bus.o_done);
    end
  endtask

  task automatic test_abort();
    int done_cnt;
    issue(3'd4, 32'd100, 32'd7);
    repeat (9) tick();
    bus.i_abort = 1'b1;
    tick();
    bus.i_abort = 1'b0;
    checks++;
    if ({bus.o_busy, bus.o_done} !== 2'b00) begin
      failures++;
      $display("FAIL abort_busy busy=%b done=%b required 0 0", bus.o_busy, bus.o_done);
    end
    done_cnt = 0;
    for (int i = 0; i < 40; i++) begin
      if (bus.o_done || bus.o_busy) done_cnt++;
      tick();
    end
    checks++;
    if ({done_cnt, bus.o_hi, bus.o_lo} !== {32'd0, 32'd0, 32'd42}) begin
      failures++;
      $display("FAIL abort_retain activity=%0d hi=%h lo=%h required 0 0/42", done_cnt, bus.o_hi, bus.o_lo);
    end
    $display("DIVU 100/7 aborted: hi=%h lo=%h", bus.o_hi, bus.o_lo);
    // Abort together with start in IDLE drops the start.
    bus.i_abort = 1'b1;
    issue(3'd2, 32'd3, 32'd3);
    bus.i_abort = 1'b0;
    checks++;
    if (bus.o_busy !== 1'b0) begin
      failures++;
      $display("FAIL abort_with_start busy=%b required 0", bus.o_busy);
    end
  endtask

  task automatic test_rst_mid();
    issue(3'd4, 32'd100, 32'd7);
    repeat (9) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++;
    if ({bus.o_busy, bus.o_done, bus.o_hi, bus.o_lo} !== {2'b00, 64'd0}) begin
      failures++;
      $display("FAIL rst_mid busy=%b done=%b hi=%h lo=%h required 0 0 0/0", bus.o_busy, bus.o_done, bus.o_hi, bus.o_lo);
    end
    repeat (40) tick();
    checks++;
    if ({bus.o_done, bus.o_hi, bus.o_lo} !== {1'b0, 64'd0}) begin
      failures++;
      $display("FAIL rst_mid_after done=%b hi=%h lo=%h required 0 0/0", bus.o_done, bus.o_hi, bus.o_lo);
    end
    $display("DIVU 100/7 reset mid-op: hi=%h lo=%h", bus.o_hi, bus.o_lo);
  endtask

  initial begin
    checks      = 0;
    failures    = 0;
    rst         = 1'b1;
    bus.i_start = 1'b0;
    bus.i_op    = 3'd0;
    bus.i_rs    = '0;
    bus.i_rt    = '0;
    bus.i_abort = 1'b0;
    tick();
    tick();
    test_reset();
    rst = 1'b0;
    tick();
    test_multu();
    test_signed();
    test_div_edges();
    test_mthi_mtlo();
    test_busy_ignore();
    test_abort();
    test_rst_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
